// File: rtl/ram8_seq_if.sv
// rtl/ram8_seq_if.sv - request/ready/ack bus between a master and the ram8_seq bank
interface ram8_seq_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
);
  logic                  clr_i;
  logic                  req_i;
  logic                  we_i;
  logic [DEPTH_LOG2-1:0] addr_i;
  logic [WIDTH-1:0]      data_i;
  logic                  ready_o;
  logic                  ack_o;
  logic [WIDTH-1:0]      data_o;
  logic                  busy_o;

  modport master (
    output clr_i, req_i, we_i, addr_i, data_i,
    input  ready_o, ack_o, data_o, busy_o
  );

  modport slave (
    input  clr_i, req_i, we_i, addr_i, data_i,
    output ready_o, ack_o, data_o, busy_o
  );
endinterface

// File: rtl/ram8_seq.sv
// rtl/ram8_seq.sv - 8-word sequential memory bank with handshake and clear sweep
// Storage is never reset directly; the CLEAR sweep zeroes one word per cycle.
module ram8_seq #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  ram8_seq_if.slave bus
);
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam int         DEPTH    = 1 << DEPTH_LOG2;

  logic [0:0]            state;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  ack_q;
  logic [WIDTH-1:0]      data_q;
  logic                  busy_q;
  logic                  ready;

  // clr_i masks ready in the same cycle so a simultaneous request waits
  assign ready       = (state == ST_IDLE) && !bus.clr_i;
  assign bus.ready_o = ready;
  assign bus.ack_o   = ack_q;
  assign bus.data_o  = data_q;
  assign bus.busy_o  = busy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state  <= ST_CLEAR;
      cnt    <= '0;
      ack_q  <= 1'b0;
      data_q <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          ack_q    <= 1'b0;
          if (&cnt) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          if (bus.clr_i) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
            ack_q  <= 1'b0;
          end else if (bus.req_i) begin
            ack_q <= 1'b1;
            if (bus.we_i) begin
              mem[bus.addr_i] <= bus.data_i;
              data_q          <= bus.data_i;
            end else begin
              data_q <= mem[bus.addr_i];
            end
          end else begin
            ack_q <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram8_seq.sv
// tb/tb_ram8_seq.sv - self-checking bench for ram8_seq
module tb_ram8_seq;
  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          acks = 0;
  int          pushes = 0;
  logic [15:0] expq [$];
  vec_t        vecs [$];
  logic [15:0] vals [8];

  ram8_seq_if #(.WIDTH(16), .DEPTH_LOG2(3)) bus ();

  ram8_seq #(.WIDTH(16), .DEPTH_LOG2(3)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.clr_i = 1'b0;
  endtask

  // Called at posedge+1; consumes exactly one accept edge when ready is high.
  task automatic do_req(input logic we, input logic [2:0] addr, input logic [15:0] d,
                        input logic [15:0] exp);
    int n = 0;
    bus.req_i  = 1'b1;
    bus.we_i   = we;
    bus.addr_i = addr;
    bus.data_i = d;
    #1;
    while (!bus.ready_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.ready_o) chk("req_timeout", {31'd0, bus.ready_o}, 32'd1);
    else begin
      expq.push_back(exp);
      pushes++;
    end
    @(posedge clk);
    #1;
  endtask

  // Returns at the first negedge with busy_o low.
  task automatic count_busy(output int n, input bit hold_en, input logic [15:0] hold);
    n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 30) begin
      chk("ready_low_busy", {31'd0, bus.ready_o}, 32'd0);
      if (hold_en) chk("data_hold_clr", {16'd0, bus.data_o}, {16'd0, hold});
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) do_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp);
    idle();
    vecs.delete();
  endtask

  task automatic add_zero_reads();
    for (int a = 0; a < 8; a++) vecs.push_back('{1'b0, 3'(a), 16'h0, 16'h0});
  endtask

  initial begin
    int          n;
    logic [15:0] hold;
    vals = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h789A, 16'h89AB};
    idle();
    bus.addr_i = 3'd0;
    bus.data_i = 16'h0;

    fork
      forever begin
        @(negedge clk);
        if (bus.ack_o === 1'b1) begin
          acks++;
          if (expq.size() == 0) chk("unexpected_ack", {31'd0, bus.ack_o}, 32'd0);
          else chk("ack_data", {16'd0, bus.data_o}, {16'd0, expq.pop_front()});
        end
      end
    join_none

    // reset and first sweep
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    chk("rst_ack", {31'd0, bus.ack_o}, 32'd0);
    chk("rst_data", {16'd0, bus.data_o}, 32'd0);
    rst_n = 1'b1;
    count_busy(n, 1'b0, 16'h0);
    chk("busy_cycles_reset", n, 8);
    chk("data_after_sweep", {16'd0, bus.data_o}, 32'd0);
    @(posedge clk);
    #1;
    add_zero_reads();
    run_vecs();

    // back-to-back writes then reads, then overwrite of one word
    for (int a = 0; a < 8; a++) vecs.push_back('{1'b1, 3'(a), vals[a], vals[a]});
    for (int a = 0; a < 8; a++) vecs.push_back('{1'b0, 3'(a), 16'h0, vals[a]});
    vecs.push_back('{1'b1, 3'd5, 16'hBEEF, 16'hBEEF});
    vecs.push_back('{1'b0, 3'd5, 16'h0, 16'hBEEF});
    vecs.push_back('{1'b0, 3'd4, 16'h0, 16'h5678});
    vecs.push_back('{1'b0, 3'd6, 16'h0, 16'h789A});
    run_vecs();

    // clear and request together: clear wins, request held until ready returns
    hold = bus.data_o;
    bus.clr_i  = 1'b1;
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 3'd6;
    #1;
    chk("ready_with_clr", {31'd0, bus.ready_o}, 32'd0);
    @(posedge clk);
    #1;
    bus.clr_i = 1'b0;
    count_busy(n, 1'b1, hold);
    chk("busy_cycles_clr", n, 8);
    expq.push_back(16'h0);
    pushes++;
    @(posedge clk);
    #1;
    idle();
    add_zero_reads();
    run_vecs();

    // reset at sweep count 3 with a read held pending
    vecs.push_back('{1'b1, 3'd3, 16'hA5A5, 16'hA5A5});
    run_vecs();
    bus.clr_i  = 1'b1;
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 3'd3;
    @(posedge clk);
    #1;
    bus.clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midsweep_rst_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("midsweep_rst_data", {16'd0, bus.data_o}, 32'd0);
    rst_n = 1'b1;
    count_busy(n, 1'b0, 16'h0);
    chk("busy_cycles_midsweep", n, 8);
    expq.push_back(16'h0);
    pushes++;
    @(posedge clk);
    #1;
    idle();

    // reset in IDLE right after an accept clears ack and data_o
    vecs.push_back('{1'b1, 3'd1, 16'h7777, 16'h7777});
    run_vecs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rst_ack", {31'd0, bus.ack_o}, 32'd0);
    chk("idle_rst_data", {16'd0, bus.data_o}, 32'd0);
    rst_n = 1'b1;
    count_busy(n, 1'b0, 16'h0);
    chk("busy_cycles_idle_rst", n, 8);
    @(posedge clk);
    #1;
    add_zero_reads();
    run_vecs();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", expq.size(), 0);
    chk("ack_count", acks, pushes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram8_seq.md
# ram8_seq

Sequential 8-word x 16-bit memory bank. It is the storage stage that directly feeds the 8-way 16-bit selector: eight 16-bit registers, a write-enable decode, and the 8-way 16-bit read selection into a registered output. Adds a request/ready/ack handshake and a hardware clear sweep, so downstream logic never reads uninitialised words. It is the building block for the RAM64-and-up hierarchy and for the register file.

## Interface
Parameters:
- WIDTH, 16, data word width; the bench exercises 16 only.
- DEPTH_LOG2, 3, address width; fixed at 3 (8 words).

Ports:
- clk_i  in  1  single clock; all state changes on the rising edge.
- rst_n_i  in  1  reset, synchronous and active-low.
- clr_i  in  1  clear request, sampled in IDLE only.
- req_i  in  1  access request, level; held by the master until accepted.
- we_i  in  1  1 = write, 0 = read; valid with req_i.
- addr_i  in  3  word address; valid with req_i.
- data_i  in  16  write data; valid with req_i and we_i.
- ready_o  out  1  combinational: (state == IDLE) && !clr_i.
- ack_o  out  1  registered one-cycle pulse, one per accepted request.
- data_o  out  16  registered read/write-through data; holds its value between acks.
- busy_o  out  1  registered: state == CLEAR.

## Operation
- States: CLEAR and IDLE. A 3-bit sweep counter `cnt` runs during CLEAR.
- Reset:
  - rst_n_i low at an edge sets state = CLEAR, cnt = 0, ack_o = 0, data_o = 0, busy_o = 1.
  - While rst_n_i is held low there are no memory writes.
  - Reset does not touch storage directly; the sweep clears it.
- CLEAR:
  - Each edge with rst_n_i high writes 0 to mem[cnt], then cnt increments.
  - The edge that writes mem[7] moves state to IDLE and sets busy_o = 0.
  - req_i and clr_i are ignored; ready_o = 0.
- IDLE, clr_i = 1:
  - Next state is CLEAR with cnt = 0.
  - ready_o is 0 that cycle, so no request is accepted and no ack follows.
- Acceptance: req_i && ready_o at a rising edge.
- Write accepted:
  - mem[addr_i] <= data_i at that edge.
  - data_o <= data_i (write-through).
  - ack_o = 1 for the next cycle.
- Read accepted:
  - data_o <= mem[addr_i] at that edge, selected by the 8-way 16-bit mux.
  - ack_o = 1 for the next cycle.
- No accept: ack_o = 0 and data_o holds.
- Throughput: back-to-back requests accepted every cycle in IDLE, no bubbles.
- Read-after-write to the same address on consecutive cycles returns the new value, because storage updates at the write edge.
- The address decode covers all 8 words; there is no out-of-range case.

## Timing
- Reset release:
  - Edge R samples rst_n_i = 1 and writes word 0; edges R+1..R+7 write words 1..7.
  - After edge R+7: state = IDLE, busy_o = 0, ready_o = 1.
  - The earliest accept is edge R+8.
- Latency: request accepted at edge N gives ack_o = 1 and valid data_o in cycle N to N+1; ack_o drops at N+1 unless another accept occurs.
- Reset mid-sweep: the sweep restarts from word 0 and takes 8 full cycles after release.
- Reset during IDLE:
  - A pending ack_o is cancelled (0 after the reset edge) and data_o = 0.
  - All 8 words read 0 after the sweep.
- clr_i in IDLE: 8-cycle sweep, same timing as reset release, except data_o is not cleared.
- clr_i and req_i high together in IDLE: clear wins, the request is not accepted, and the master keeps req_i high until ready_o returns.

## Test plan
- Reset for 2 cycles, then release -> busy_o = 1 and ready_o = 0 for exactly 8 cycles; data_o = 0x0000; reads of words 0..7 all return 0x0000.
- Write words 0..7 = 0x1234, 0x2345, 0x3456, 0x4567, 0x5678, 0x6789, 0x789A, 0x89AB back-to-back -> 8 ack pulses on consecutive cycles, data_o echoes each value; then read addr 0..7 -> 0x1234 .. 0x89AB in order, 1-cycle latency each.
- Write addr 5 = 0xBEEF, then read addr 5 the next cycle -> data_o = 0xBEEF; addr 4 still 0x5678 and addr 6 still 0x789A.
- With the memory loaded, assert clr_i and req_i together for 1 cycle -> no ack that cycle, 8 busy cycles, data_o unchanged during the sweep; all words read 0x0000 afterwards.
- Assert reset at sweep count 3, then release -> full 8-cycle sweep from word 0; no ack during CLEAR even with req_i held high.
- req_i high with ready_o low, then ready_o rises -> exactly one ack per accept edge; no ack is generated for the cycles the request was stalled.
